// File: rtl/wasm_cpu.sv
// Minimal WebAssembly interpreter core: fetches an 11-byte window per instruction
// from genrom and executes a small integer subset on a 64-bit operand stack.
module wasm_cpu #(
  parameter int MEM_DEPTH   = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [63:0]          result,
  output logic                 result_empty,
  output logic [3:0]           trap,
  output logic [MEM_DEPTH:0]   mem_addr,
  output logic [3:0]           mem_extra,
  input  logic [127:0]         mem_data,
  input  logic                 mem_error,
  output logic [1:0]           fsm_state
);

  localparam int SW    = STACK_DEPTH + 1;
  localparam int SLOTS = 2 ** STACK_DEPTH;

  localparam logic [3:0] TRAP_RUN       = 4'd0;
  localparam logic [3:0] TRAP_END       = 4'd1;
  localparam logic [3:0] TRAP_UNREACH   = 4'd2;
  localparam logic [3:0] TRAP_OPCODE    = 4'd3;
  localparam logic [3:0] TRAP_UNDERFLOW = 4'd4;
  localparam logic [3:0] TRAP_OVERFLOW  = 4'd5;
  localparam logic [3:0] TRAP_MEM       = 4'd6;
  localparam logic [3:0] TRAP_LEB       = 4'd7;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [MEM_DEPTH:0]   pc, pc_next;
  logic [SW-1:0]        sp, sp_next, sp_pop;
  logic [63:0]          result_q, result_next;
  logic [3:0]           trap_q, trap_next, exec_trap;
  logic [63:0]          stack_mem [SLOTS];

  logic                 push_req, push_en;
  logic [63:0]          push_val;
  logic [STACK_DEPTH-1:0] push_idx;
  logic [1:0]           pop_cnt;
  logic [3:0]           inst_len;
  logic [7:0]           opcode;
  logic [31:0]          top32, nxt32;

  logic [69:0]          leb_raw, leb_full;
  logic                 leb_done, leb_sign;
  logic [3:0]           leb_len;
  logic                 unused_bits;

  // Fetch protocol: mem_addr/mem_extra are held at pc for the whole
  // instruction; genrom answers one cycle later, so the window is valid in EXEC.
  assign mem_addr     = pc;
  assign mem_extra    = 4'd10;
  assign result       = result_q;
  assign trap         = trap_q;
  assign result_empty = (sp == '0);
  assign fsm_state    = state;

  assign opcode = mem_data[7:0];
  assign top32  = stack_mem[STACK_DEPTH'(sp - SW'(1))][31:0];
  assign nxt32  = stack_mem[STACK_DEPTH'(sp - SW'(2))][31:0];

  assign unused_bits = &{1'b0, leb_full[69:64], mem_data[127:88]};

  // Signed LEB128 scan over window bytes 1..10; leb_len counts bytes consumed.
  always_comb begin
    leb_raw  = '0;
    leb_done = 1'b0;
    leb_sign = 1'b0;
    leb_len  = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (!leb_done) begin
        leb_raw[7*k +: 7] = mem_data[8*(k+1) +: 7];
        leb_len           = 4'(k + 1);
        if (!mem_data[8*(k+1)+7]) begin
          leb_done = 1'b1;
          leb_sign = mem_data[8*(k+1)+6];
        end
      end
    end
    leb_full = leb_raw | (leb_sign ? ({70{1'b1}} << (7 * leb_len)) : 70'd0);
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    sp_next     = sp;
    result_next = result_q;
    trap_next   = trap_q;
    exec_trap   = TRAP_RUN;
    push_req    = 1'b0;
    push_en     = 1'b0;
    push_val    = '0;
    push_idx    = '0;
    pop_cnt     = 2'd0;
    inst_len    = 4'd1;
    sp_pop      = sp;

    case (state)
      FETCH: state_next = EXEC;

      EXEC: begin
        state_next = FETCH;
        if (mem_error) begin
          exec_trap = TRAP_MEM;
        end else begin
          case (opcode)
            8'h00: exec_trap = TRAP_UNREACH;
            8'h01: ;
            8'h0B: exec_trap = TRAP_END;
            8'h1A: pop_cnt = 2'd1;
            8'h41: begin
              if (leb_done && leb_len <= 4'd5) begin
                push_req = 1'b1;
                push_val = {32'd0, leb_full[31:0]};
                inst_len = leb_len + 4'd1;
              end else begin
                exec_trap = TRAP_LEB;
              end
            end
            8'h42: begin
              if (leb_done) begin
                push_req = 1'b1;
                push_val = leb_full[63:0];
                inst_len = leb_len + 4'd1;
              end else begin
                exec_trap = TRAP_LEB;
              end
            end
            8'h45: begin
              pop_cnt  = 2'd1;
              push_req = 1'b1;
              push_val = {63'd0, top32 == 32'd0};
            end
            8'h46: begin
              pop_cnt  = 2'd2;
              push_req = 1'b1;
              push_val = {63'd0, nxt32 == top32};
            end
            8'h47: begin
              pop_cnt  = 2'd2;
              push_req = 1'b1;
              push_val = {63'd0, nxt32 != top32};
            end
            8'h6A: begin
              pop_cnt  = 2'd2;
              push_req = 1'b1;
              push_val = {32'd0, nxt32 + top32};
            end
            8'h6B: begin
              pop_cnt  = 2'd2;
              push_req = 1'b1;
              push_val = {32'd0, nxt32 - top32};
            end
            default: exec_trap = TRAP_OPCODE;
          endcase
        end

        // Stack checks happen before any state change so a trap leaves it intact.
        if (exec_trap == TRAP_RUN) begin
          if (sp < SW'(pop_cnt)) begin
            exec_trap = TRAP_UNDERFLOW;
          end else if (push_req && pop_cnt == 2'd0 && sp == SW'(SLOTS)) begin
            exec_trap = TRAP_OVERFLOW;
          end
        end

        if (exec_trap != TRAP_RUN) begin
          trap_next  = exec_trap;
          state_next = HALT;
        end else begin
          sp_pop  = sp - SW'(pop_cnt);
          sp_next = sp_pop + SW'(push_req);
          pc_next = pc + (MEM_DEPTH+1)'(inst_len);
          if (push_req) begin
            push_en     = 1'b1;
            push_idx    = STACK_DEPTH'(sp_pop);
            result_next = push_val;
          end else if (sp_next == '0) begin
            result_next = '0;
          end else begin
            result_next = stack_mem[STACK_DEPTH'(sp_next - SW'(1))];
          end
        end
      end

      HALT: ;

      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      pc       <= '0;
      sp       <= '0;
      result_q <= '0;
      trap_q   <= TRAP_RUN;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      sp       <= sp_next;
      result_q <= result_next;
      trap_q   <= trap_next;
    end
  end

  // Writes only happen in EXEC, and reset forces FETCH, so an aborted
  // instruction can never leave a stray entry behind.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= push_val;
    end
  end

endmodule

// File: tb/tb_wasm_cpu.sv
// Bench for wasm_cpu: behavioural genrom, directed programs with fixed answers,
// and random programs checked against an instruction-level interpreter model.
module tb_wasm_cpu;

  logic         clk;
  logic         reset;
  logic [63:0]  result;
  logic         result_empty;
  logic [3:0]   trap;
  logic [16:0]  mem_addr;
  logic [3:0]   mem_extra;
  logic [127:0] mem_data;
  logic         mem_error;
  logic [1:0]   fsm_state;

  logic [7:0] rom [0:511];
  int         upper_bound;
  int         lower_bound;
  int         checks;
  int         errors;

  wasm_cpu #(.MEM_DEPTH(16), .STACK_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .result       (result),
    .result_empty (result_empty),
    .trap         (trap),
    .mem_addr     (mem_addr),
    .mem_extra    (mem_extra),
    .mem_data     (mem_data),
    .mem_error    (mem_error),
    .fsm_state    (fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input int a);
    if (a >= 0 && a < 512) return rom[a];
    return 8'h00;
  endfunction

  // genrom: registered read of mem_extra+1 bytes, bounds checked
  always @(posedge clk) begin
    for (int k = 0; k < 16; k++)
      mem_data[8*k +: 8] <= (k <= int'(mem_extra)) ? rom_byte(int'(mem_addr) + k) : 8'h00;
    mem_error <= (int'(mem_addr) + int'(mem_extra) > upper_bound) ||
                 (int'(mem_addr) < lower_bound) ||
                 (int'(mem_addr) + int'(mem_extra) >= (1 << 17));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return 4'(c - 8'h30);
    if (c >= 8'h41 && c <= 8'h46) return 4'(c - 8'h37);
    return 4'h0;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) rom[i] = 8'h00;
  endtask

  task automatic load_hex(input string s);
    int p;
    int nib;
    logic [7:0] v;
    logic [7:0] c;
    clear_rom();
    p = 0; nib = 0; v = 8'h00;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c != 8'h20) begin
        v = {v[3:0], hex_nib(c)};
        nib++;
        if (nib == 2) begin
          rom[p] = v;
          p++;
          nib = 0;
        end
      end
    end
  endtask

  // ---------------- reference model ----------------
  task automatic leb_decode(input int at, input int limit, output bit ok, output int n,
                            output logic [63:0] v);
    logic [127:0] acc;
    logic [7:0] b;
    acc = '0; ok = 1'b0; n = 0;
    for (int i = 0; i < limit; i++) begin
      b = rom_byte(at + i);
      acc = acc | (128'(b & 8'h7F) << (7 * i));
      if (!b[7]) begin
        ok = 1'b1;
        n = i + 1;
        if (b[6]) acc = acc | ({128{1'b1}} << (7 * (i + 1)));
        break;
      end
    end
    v = acc[63:0];
  endtask

  task automatic model_run(output logic [63:0] e_res, output logic e_empty,
                           output logic [3:0] e_trap, output int e_pc, output int e_cyc);
    logic [63:0] q[$];
    logic [63:0] v, a, b, r;
    logic [7:0] op;
    logic [3:0] t;
    bit ok;
    int n, pc, steps;
    pc = 0; steps = 0; t = 4'd0;
    while (t == 4'd0 && steps < 1000) begin
      steps++;
      if (pc + 10 > upper_bound || pc < lower_bound) begin
        t = 4'd6;
      end else begin
        op = rom_byte(pc);
        case (op)
          8'h00: t = 4'd2;
          8'h01: pc += 1;
          8'h0B: t = 4'd1;
          8'h1A: begin
            if (q.size() < 1) t = 4'd4;
            else begin
              void'(q.pop_back());
              pc += 1;
            end
          end
          8'h41, 8'h42: begin
            leb_decode(pc + 1, (op == 8'h41) ? 5 : 10, ok, n, v);
            if (!ok) t = 4'd7;
            else if (q.size() >= 16) t = 4'd5;
            else begin
              q.push_back((op == 8'h41) ? {32'd0, v[31:0]} : v);
              pc += 1 + n;
            end
          end
          8'h45: begin
            if (q.size() < 1) t = 4'd4;
            else begin
              a = q.pop_back();
              q.push_back((a[31:0] == 32'd0) ? 64'd1 : 64'd0);
              pc += 1;
            end
          end
          8'h46, 8'h47, 8'h6A, 8'h6B: begin
            if (q.size() < 2) t = 4'd4;
            else begin
              b = q.pop_back();
              a = q.pop_back();
              if (op == 8'h46)      r = (a[31:0] == b[31:0]) ? 64'd1 : 64'd0;
              else if (op == 8'h47) r = (a[31:0] != b[31:0]) ? 64'd1 : 64'd0;
              else if (op == 8'h6A) r = {32'd0, a[31:0] + b[31:0]};
              else                  r = {32'd0, a[31:0] - b[31:0]};
              q.push_back(r);
              pc += 1;
            end
          end
          default: t = 4'd3;
        endcase
      end
    end
    e_res   = (q.size() > 0) ? q[q.size() - 1] : 64'd0;
    e_empty = (q.size() == 0);
    e_trap  = t;
    e_pc    = pc;
    e_cyc   = 2 * steps;
  endtask

  task automatic gen_prog();
    int p, n, r, len, lim;
    logic [7:0] b;
    clear_rom();
    p = 0;
    n = $urandom_range(3, 20);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        rom[p] = (r < 30) ? 8'h41 : 8'h42;
        lim = (r < 30) ? 5 : 10;
        p++;
        len = $urandom_range(1, lim);
        for (int j = 0; j < len; j++) begin
          b = 8'($urandom_range(0, 255));
          rom[p] = (j == len - 1) ? {1'b0, b[6:0]} : {1'b1, b[6:0]};
          p++;
        end
      end else if (r >= 96) begin
        rom[p] = 8'h41;
        p++;
        for (int j = 0; j < 5; j++) begin
          rom[p] = 8'h80 | 8'($urandom_range(0, 127));
          p++;
        end
      end else begin
        if (r < 55)      rom[p] = 8'h45;
        else if (r < 62) rom[p] = 8'h46;
        else if (r < 69) rom[p] = 8'h47;
        else if (r < 78) rom[p] = 8'h6A;
        else if (r < 87) rom[p] = 8'h6B;
        else if (r < 91) rom[p] = 8'h1A;
        else if (r < 94) rom[p] = 8'h01;
        else             rom[p] = 8'($urandom_range(0, 255));
        p++;
      end
    end
    rom[p] = 8'h0B;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_dut(input string tag, output int cyc);
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check({tag, "_rst_result"}, result, 64'd0);
    check({tag, "_rst_empty"}, 64'(result_empty), 64'd1);
    check({tag, "_rst_trap"}, 64'(trap), 64'd0);
    check({tag, "_rst_addr"}, 64'(mem_addr), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (trap === 4'd0 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    // outputs must hold in HALT
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_expect(input string tag, input logic [63:0] e_res, input logic e_empty,
                            input logic [3:0] e_trap, input int e_pc, input int e_cyc);
    int cyc;
    run_dut(tag, cyc);
    check({tag, "_cycles"}, 64'(cyc), 64'(e_cyc));
    check({tag, "_trap"}, 64'(trap), 64'(e_trap));
    check({tag, "_result"}, result, e_res);
    check({tag, "_empty"}, 64'(result_empty), 64'(e_empty));
    check({tag, "_pc"}, 64'(mem_addr), 64'(e_pc));
  endtask

  initial begin
    logic [63:0] m_res;
    logic m_empty;
    logic [3:0] m_trap;
    int m_pc, m_cyc;

    checks = 0;
    errors = 0;
    reset = 1'b0;
    upper_bound = (1 << 17) - 1;
    lower_bound = 0;
    clear_rom();

    load_hex("41 00 45 0B");
    run_expect("eqz_zero", 64'd1, 1'b0, 4'd1, 3, 6);
    check("mem_extra", 64'(mem_extra), 64'd10);
    load_hex("41 05 45 0B");
    run_expect("eqz_five", 64'd0, 1'b0, 4'd1, 3, 6);
    load_hex("41 7F 41 02 6A 0B");
    run_expect("add_m1_2", 64'd1, 1'b0, 4'd1, 5, 8);
    load_hex("41 00 41 01 6B 0B");
    run_expect("sub_0_1", 64'h0000_0000_FFFF_FFFF, 1'b0, 4'd1, 5, 8);
    load_hex("45 0B");
    run_expect("underflow", 64'd0, 1'b1, 4'd4, 0, 2);
    load_hex("00");
    run_expect("unreachable", 64'd0, 1'b1, 4'd2, 0, 2);
    load_hex("FF");
    run_expect("bad_opcode", 64'd0, 1'b1, 4'd3, 0, 2);
    load_hex("41 80 80 80 80 80 0B");
    run_expect("leb_i32_long", 64'd0, 1'b1, 4'd7, 0, 2);
    load_hex("41 FF FF FF FF 0F 0B");
    run_expect("leb_i32_5byte", 64'h0000_0000_FFFF_FFFF, 1'b0, 4'd1, 6, 4);
    load_hex("42 7F 0B");
    run_expect("i64_m1", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd1, 2, 4);
    load_hex("41 03 41 03 46 0B");
    run_expect("eq_true", 64'd1, 1'b0, 4'd1, 5, 8);
    load_hex("41 03 41 04 47 0B");
    run_expect("ne_true", 64'd1, 1'b0, 4'd1, 5, 8);
    load_hex("41 01 41 02 1A 0B");
    run_expect("drop", 64'd1, 1'b0, 4'd1, 5, 8);

    clear_rom();
    for (int i = 0; i < 17; i++) begin
      rom[2*i]     = 8'h41;
      rom[2*i + 1] = 8'h01;
    end
    rom[34] = 8'h0B;
    run_expect("overflow", 64'd1, 1'b0, 4'd5, 32, 34);

    load_hex("01 01 0B");
    upper_bound = 11;
    run_expect("mem_error", 64'd0, 1'b1, 4'd6, 2, 6);
    upper_bound = (1 << 17) - 1;

    // reset after the first EXEC of 41 2A 0B
    load_hex("41 2A 0B");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_pre_result", result, 64'd42);
    reset = 1'b0;
    #1;
    check("mid_async_result", result, 64'd0);
    check("mid_async_empty", 64'(result_empty), 64'd1);
    check("mid_async_trap", 64'(trap), 64'd0);
    check("mid_async_addr", 64'(mem_addr), 64'd0);
    run_expect("mid_rerun", 64'd42, 1'b0, 4'd1, 2, 4);

    // reset held across the EXEC edge: nothing may be pushed
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_exec_empty", 64'(result_empty), 64'd1);
    check("abort_exec_result", result, 64'd0);
    @(negedge clk);

    for (int it = 0; it < 25; it++) begin
      gen_prog();
      model_run(m_res, m_empty, m_trap, m_pc, m_cyc);
      run_expect($sformatf("rnd%0d", it), m_res, m_empty, m_trap, m_pc, m_cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
